// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: decodes SPI command bytes into frame RAM writes, frame length and refresh requests.
// Optional status readback (opcode 0x0F) is built when SPI_CMD_READBACK_EN is defined.
module spi_cmd_decoder #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  spi_cs_n_i,
   input  logic                  spi_byte_vld_i,
   input  logic [7:0]            spi_byte_data_i,
   output logic [7:0]            spi_byte_data_o,
   input  logic                  frame_busy_i,
   output logic                  ram_wr_en_o,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
   output logic [7:0]            ram_wr_data_o,
   output logic [15:0]           frame_len_o,
   output logic                  frame_start_o
);
   typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, WR_DATA, DISCARD, STATUS} state_t;
   state_t state, state_d;
   logic [1:0] cs_ff;
   logic cs_sync, take;
   logic [7:0] hi;
   logic [15:0] hi_lo;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   assign cs_sync = cs_ff[1];
   assign take = spi_byte_vld_i && !cs_sync;
   assign hi_lo = {hi, spi_byte_data_i};
   // cs_n powers up deasserted so the decoder sits in IDLE until the master selects it
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cs_ff <= 2'b11;
      else cs_ff <= {cs_ff[0], spi_cs_n_i};
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state <= IDLE;
      else state <= state_d;
   always_comb begin
      state_d = state;
      if (cs_sync) state_d = IDLE;
      else if (spi_byte_vld_i)
         case (state)
            IDLE:
               case (spi_byte_data_i)
                  8'h00: state_d = IDLE;
                  8'h2A: state_d = ADDR_H;
                  8'h3A: state_d = LEN_H;
                  8'h2C: state_d = WR_DATA;
                  8'h29: state_d = DISCARD;
`ifdef SPI_CMD_READBACK_EN
                  8'h0F: state_d = STATUS;
`endif
                  default: state_d = DISCARD;
               endcase
            ADDR_H: state_d = ADDR_L;
            LEN_H: state_d = LEN_L;
            ADDR_L, LEN_L, STATUS: state_d = DISCARD;
            default: state_d = state;
         endcase
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         hi <= 8'h00;
         wr_ptr <= '0;
         ram_wr_en_o <= 1'b0;
         ram_wr_addr_o <= '0;
         ram_wr_data_o <= 8'h00;
         frame_len_o <= 16'h0000;
         frame_start_o <= 1'b0;
      end else begin
         ram_wr_en_o <= take && state == WR_DATA;
         frame_start_o <= take && state == IDLE && spi_byte_data_i == 8'h29;
         if (take && (state == ADDR_H || state == LEN_H)) hi <= spi_byte_data_i;
         if (take && state == ADDR_L) wr_ptr <= hi_lo[ADDR_WIDTH-1:0];
         if (take && state == LEN_L) frame_len_o <= hi_lo;
         if (take && state == WR_DATA) begin
            ram_wr_addr_o <= wr_ptr;
            ram_wr_data_o <= spi_byte_data_i;
            wr_ptr <= wr_ptr + 1'b1;
         end
      end
`ifdef SPI_CMD_READBACK_EN
   logic wrap_flag, badcmd_flag, flag_clr, wrap_hit, bad_hit;
   logic [7:0] rb;
   assign flag_clr = take && state == STATUS;
   assign wrap_hit = take && state == WR_DATA && &wr_ptr;
   assign bad_hit = take && state == IDLE && state_d == DISCARD && spi_byte_data_i != 8'h29;
   // status snapshot is taken on the 0x0F byte and held only while still in STATUS
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         wrap_flag <= 1'b0;
         badcmd_flag <= 1'b0;
         rb <= 8'h00;
      end else begin
         wrap_flag <= (wrap_flag || wrap_hit) && !flag_clr;
         badcmd_flag <= (badcmd_flag || bad_hit) && !flag_clr;
         rb <= (take && state == IDLE && spi_byte_data_i == 8'h0F) ?
               {frame_busy_i, wrap_flag, badcmd_flag, 5'b0} : (state_d == STATUS ? rb : 8'h00);
      end
   assign spi_byte_data_o = rb;
`else
   logic unused_busy;
   assign unused_busy = frame_busy_i;
   assign spi_byte_data_o = 8'h00;
`endif
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: transaction-level reference model plus directed and randomized command streams.
module tb_spi_cmd_decoder;
   localparam int AW = 10;
   localparam int SIZE = 1 << AW;
   logic clk = 0, rst = 1, cs = 1, vld = 0, busy = 0;
   logic [7:0] din = 0;
   logic [7:0] dout;
   logic wr_en, fstart;
   logic [AW-1:0] wr_addr;
   logic [7:0] wr_data;
   logic [15:0] flen;
   int errors = 0, checks = 0;
   bit busy_force = 0;

   spi_cmd_decoder #(.ADDR_WIDTH(AW)) dut (
      .clk_i(clk), .rst_i(rst), .spi_cs_n_i(cs), .spi_byte_vld_i(vld), .spi_byte_data_i(din),
      .spi_byte_data_o(dout), .frame_busy_i(busy), .ram_wr_en_o(wr_en), .ram_wr_addr_o(wr_addr),
      .ram_wr_data_o(wr_data), .frame_len_o(flen), .frame_start_o(fstart)
   );

   always #5 clk = ~clk;
   always @(negedge clk) busy = busy_force | 1'($urandom_range(0, 1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: a transaction is an opcode (first non-zero byte) followed by numbered argument bytes.
   logic [1:0] csd = 2'b11;
   int op = -1, cnt = 0, ptr = 0;
   logic [7:0] hi = 0;
   logic exp_en = 0, exp_start = 0;
   int exp_addr = 0, exp_data = 0;
   logic [15:0] exp_len = 0;
   logic [7:0] exp_spi = 0;
`ifdef SPI_CMD_READBACK_EN
   logic wrap = 0, bad = 0;
`endif

   function automatic bit known(input logic [7:0] b);
`ifdef SPI_CMD_READBACK_EN
      return b inside {8'h00, 8'h2A, 8'h3A, 8'h2C, 8'h29, 8'h0F};
`else
      return b inside {8'h00, 8'h2A, 8'h3A, 8'h2C, 8'h29};
`endif
   endfunction

   always @(posedge clk) begin : model
      logic sync;
      if (rst) begin
         csd = 2'b11; op = -1; cnt = 0; ptr = 0; hi = 0;
         exp_en = 0; exp_start = 0; exp_len = 0; exp_spi = 0;
`ifdef SPI_CMD_READBACK_EN
         wrap = 0; bad = 0;
`endif
      end else begin
         sync = csd[1];
         csd = {csd[0], cs};
         exp_en = 0;
         exp_start = 0;
         if (sync) begin
            op = -1; cnt = 0; exp_spi = 0;
         end else if (vld) begin
            if (op < 0) begin
               if (din != 8'h00) begin
                  op = int'(din);
                  cnt = 0;
                  if (din == 8'h29) exp_start = 1;
`ifdef SPI_CMD_READBACK_EN
                  if (din == 8'h0F) exp_spi = {busy, wrap, bad, 5'b0};
                  if (!known(din)) bad = 1;
`endif
               end
            end else begin
               cnt++;
               if ((op == 'h2A || op == 'h3A) && cnt == 1) hi = din;
               if (op == 'h2A && cnt == 2) ptr = int'({hi, din}) % SIZE;
               if (op == 'h3A && cnt == 2) exp_len = {hi, din};
               if (op == 'h2C) begin
                  exp_en = 1; exp_addr = ptr; exp_data = int'(din);
`ifdef SPI_CMD_READBACK_EN
                  if (ptr == SIZE - 1) wrap = 1;
`endif
                  ptr = (ptr + 1) % SIZE;
               end
`ifdef SPI_CMD_READBACK_EN
               if (op == 'h0F && cnt == 1) begin
                  wrap = 0; bad = 0; exp_spi = 0;
               end
`endif
            end
         end
      end
   end

   int cyc = 0, starts = 0;
   int log_q[$], cyc_q[$];
   always @(posedge clk) begin
      #3;
      cyc++;
      if (!rst) begin
         chk("wr_en", 32'(wr_en), 32'(exp_en));
         if (exp_en) begin
            chk("wr_addr", 32'(wr_addr), exp_addr);
            chk("wr_data", 32'(wr_data), exp_data);
         end
         chk("frame_start", 32'(fstart), 32'(exp_start));
         chk("frame_len", 32'(flen), 32'(exp_len));
         chk("spi_out", 32'(dout), 32'(exp_spi));
         if (wr_en) begin
            log_q.push_back(int'(wr_addr) * 256 + int'(wr_data));
            cyc_q.push_back(cyc);
         end
         if (fstart) starts++;
      end
   end

   logic [7:0] tx_q[$];
   task automatic put(input logic [7:0] b);
      @(negedge clk); vld = 1; din = b;
   endtask
   task automatic idle(input int n);
      repeat (n) begin @(negedge clk); vld = 0; end
   endtask
   task automatic cs_set(input logic v);
      idle(1); cs = v; idle(4);
   endtask
   task automatic txn(input bit tight);
      cs_set(0);
      foreach (tx_q[i]) begin
         put(tx_q[i]);
         if (!tight) idle($urandom_range(0, 2));
      end
      cs_set(1);
      tx_q.delete();
   endtask

   initial begin
      logic [7:0] ops[7];
      ops = '{8'h2A, 8'h3A, 8'h2C, 8'h29, 8'h00, 8'h0F, 8'h77};
      repeat (3) @(negedge clk);
      rst = 0;
      chk("reset_len", 32'(flen), 0);
      chk("reset_spi", 32'(dout), 0);
      chk("reset_wr_en", 32'(wr_en), 0);
      chk("reset_start", 32'(fstart), 0);
      idle(2);
      log_q.delete();
      tx_q = '{8'h2A, 8'h00, 8'h05}; txn(0);
      tx_q = '{8'h2C, 8'h11, 8'h22}; txn(0);
      chk("t1_count", log_q.size(), 2);
      chk("t1_w0", log_q[0], 5 * 256 + 'h11);
      chk("t1_w1", log_q[1], 6 * 256 + 'h22);
      log_q.delete();
      tx_q = '{8'h2A, 8'h03, 8'hFF}; txn(0);
      tx_q = '{8'h2C, 8'hAA, 8'hBB}; txn(0);
      chk("t2_w0", log_q[0], 1023 * 256 + 'hAA);
      chk("t2_w1", log_q[1], 'hBB);
      tx_q = '{8'h3A, 8'h01, 8'h2C}; txn(0);
      chk("t3_len", 32'(flen), 'h012C);
      starts = 0;
      tx_q = '{8'h29}; txn(0);
      chk("t3_starts", starts, 1);
      log_q.delete(); cyc_q.delete();
      tx_q = '{8'h2C, 8'h01, 8'h02, 8'h03, 8'h04}; txn(1);
      chk("t4_count", log_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t4_addr", log_q[i] >> 8, 1 + i);
         chk("t4_cycle", cyc_q[i] - cyc_q[0], i);
      end
      log_q.delete();
      tx_q = '{8'h2A, 8'h12}; txn(0);
      tx_q = '{8'h2C, 8'h55}; txn(0);
      chk("t5_w0", log_q[0], 5 * 256 + 'h55);
`ifdef SPI_CMD_READBACK_EN
      tx_q = '{8'h0F, 8'h00}; txn(0);
      tx_q = '{8'h77}; txn(0);
      busy_force = 1;
      cs_set(0); put(8'h0F); idle(2);
      chk("t6_status", 32'(dout), 'hA0);
      put(8'h00); idle(2);
      chk("t6_after", 32'(dout), 0);
      cs_set(1);
      cs_set(0); put(8'h0F); idle(2);
      chk("t6_status2", 32'(dout), 'h80);
      cs_set(1);
      busy_force = 0;
`else
      log_q.delete();
      cs_set(0); put(8'h0F); idle(2);
      chk("t6_no_readback", 32'(dout), 0);
      put(8'h2C); put(8'h66); idle(2);
      chk("t6_discard", log_q.size(), 0);
      cs_set(1);
`endif
      cs_set(0); put(8'h2A); put(8'h12); idle(1);
      @(negedge clk); rst = 1; cs = 1; vld = 0;
      #1;
      chk("t7_rst_len", 32'(flen), 0);
      chk("t7_rst_en", 32'(wr_en), 0);
      repeat (2) @(negedge clk);
      rst = 0;
      idle(4);
      log_q.delete();
      tx_q = '{8'h2C, 8'h55}; txn(0);
      chk("t7_w0", log_q[0], 'h55);
      for (int n = 0; n < 300; n++) begin
         tx_q.push_back($urandom_range(0, 7) == 7 ? 8'($urandom) : ops[$urandom_range(0, 6)]);
         if ($urandom_range(0, 3) == 0) tx_q.push_back(8'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 5)) tx_q.push_back(8'($urandom));
         txn(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 4) == 0) begin
            put(8'($urandom)); idle(2);
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
